// File: rtl/fetch_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fetch_sequencer_pkg
// Purpose : Shared definitions for the IF-stage fetch sequencer.
//           - FSM state encoding (IDLE / REQ / HOLD, 2 bits)
//           - default address/instruction width and reset vector
// Revision: 1.0  initial release
// ============================================================================
package fetch_sequencer_pkg;

  localparam int          FS_WIDTH     = 32;
  localparam logic [31:0] FS_RESET_VEC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // first cycle after reset, no request yet
    ST_REQ  = 2'd1,  // fetch request outstanding on the I-memory port
    ST_HOLD = 2'd2   // fetched word presented to IF/ID, waiting for ready
  } fs_state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_sequencer_pc_incr.sv
`default_nettype none
// ============================================================================
// Module  : fetch_sequencer_pc_incr
// Purpose : Word-address incrementer (pc_incr). Combinational +1, modulo
//           2^WIDTH; the all-ones address wraps to zero with no carry out.
// Ports   : addr_i      in  WIDTH  address to increment
//           addr_inc_o  out WIDTH  addr_i + 1
// Revision: 1.0  initial release
// ============================================================================
module fetch_sequencer_pc_incr #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] addr_i,
  output logic [WIDTH-1:0] addr_inc_o
);

  assign addr_inc_o = addr_i + WIDTH'(1);

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : fetch_sequencer
// Purpose : IF-stage program-counter controller. Owns the PC, issues one
//           outstanding fetch at a time to instruction memory, presents the
//           fetched word to IF/ID with valid/ready, and applies EX redirects,
//           discarding any fetch that was in flight when a redirect arrived.
// Ports   : clk_i              in   1      rising-edge clock
//           reset_i            in   1      asynchronous active-high reset
//           redirect_valid_i   in   1      EX requests a PC change
//           redirect_target_i  in   WIDTH  new PC
//           imem_req_o         out  1      fetch request (held until ack)
//           imem_addr_o        out  WIDTH  fetch address
//           imem_ack_i         in   1      memory returns imem_rdata_i
//           imem_rdata_i       in   WIDTH  fetched instruction
//           fetch_valid_o      out  1      fetch_instr_o/fetch_pc_o valid
//           fetch_ready_i      in   1      IF/ID accepts this cycle
//           fetch_instr_o      out  WIDTH  instruction to IF/ID
//           fetch_pc_o         out  WIDTH  address of fetch_instr_o
// Revision: 1.0  initial release
// ============================================================================
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int               WIDTH     = FS_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(FS_RESET_VEC)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             redirect_valid_i,
  input  logic [WIDTH-1:0] redirect_target_i,
  output logic             imem_req_o,
  output logic [WIDTH-1:0] imem_addr_o,
  input  logic             imem_ack_i,
  input  logic [WIDTH-1:0] imem_rdata_i,
  output logic             fetch_valid_o,
  input  logic             fetch_ready_i,
  output logic [WIDTH-1:0] fetch_instr_o,
  output logic [WIDTH-1:0] fetch_pc_o
);

  fs_state_e        state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;             // next sequential fetch address
  logic [WIDTH-1:0] req_addr_q, req_addr_d; // address of current/next request
  logic             kill_q, kill_d;         // in-flight fetch is stale
  logic             imem_req_q, imem_req_d;
  logic [WIDTH-1:0] imem_addr_q;
  logic             fetch_valid_q, fetch_valid_d;
  logic [WIDTH-1:0] fetch_instr_q, fetch_instr_d;
  logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [WIDTH-1:0] req_addr_inc;

  fetch_sequencer_pc_incr #(
    .WIDTH (WIDTH)
  ) u_pc_incr (
    .addr_i     (req_addr_q),
    .addr_inc_o (req_addr_inc)
  );

  // Next-state logic. Redirect has top priority in every state.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_addr_d    = req_addr_q;
    kill_d        = kill_q;
    imem_req_d    = 1'b0;
    fetch_valid_d = 1'b0;
    fetch_instr_d = fetch_instr_q;
    fetch_pc_d    = fetch_pc_q;

    case (state_q)
      ST_IDLE: begin
        state_d    = ST_REQ;
        imem_req_d = 1'b1;
        if (redirect_valid_i) begin
          pc_d       = redirect_target_i;
          req_addr_d = redirect_target_i;
        end else begin
          req_addr_d = pc_q;
        end
      end

      ST_REQ: begin
        imem_req_d = 1'b1;
        if (redirect_valid_i && imem_ack_i) begin
          // Returning word is for the old path: drop it and start the
          // target fetch right away.
          pc_d       = redirect_target_i;
          req_addr_d = redirect_target_i;
          kill_d     = 1'b0;
        end else if (redirect_valid_i) begin
          // Cannot withdraw a request in flight; mark it stale and keep
          // the address stable. A later redirect simply overwrites pc.
          pc_d   = redirect_target_i;
          kill_d = 1'b1;
        end else if (imem_ack_i && kill_q) begin
          kill_d     = 1'b0;
          req_addr_d = pc_q;
        end else if (imem_ack_i) begin
          fetch_instr_d = imem_rdata_i;
          fetch_pc_d    = req_addr_q;
          pc_d          = req_addr_inc;
          fetch_valid_d = 1'b1;
          imem_req_d    = 1'b0;
          state_d       = ST_HOLD;
        end
      end

      ST_HOLD: begin
        fetch_valid_d = 1'b1;
        if (redirect_valid_i) begin
          // Word is consumed if ready is also high; either way it is gone.
          pc_d          = redirect_target_i;
          req_addr_d    = redirect_target_i;
          fetch_valid_d = 1'b0;
          imem_req_d    = 1'b1;
          state_d       = ST_REQ;
        end else if (fetch_ready_i) begin
          req_addr_d    = pc_q;
          fetch_valid_d = 1'b0;
          imem_req_d    = 1'b1;
          state_d       = ST_REQ;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Single state/output register bank; async reset drops imem_req at once.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_VEC;
      req_addr_q    <= RESET_VEC;
      kill_q        <= 1'b0;
      imem_req_q    <= 1'b0;
      imem_addr_q   <= '0;
      fetch_valid_q <= 1'b0;
      fetch_instr_q <= '0;
      fetch_pc_q    <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_addr_q    <= req_addr_d;
      kill_q        <= kill_d;
      imem_req_q    <= imem_req_d;
      imem_addr_q   <= req_addr_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_instr_q <= fetch_instr_d;
      fetch_pc_q    <= fetch_pc_d;
    end
  end

  assign imem_req_o    = imem_req_q;
  assign imem_addr_o   = imem_addr_q;
  assign fetch_valid_o = fetch_valid_q;
  assign fetch_instr_o = fetch_instr_q;
  assign fetch_pc_o    = fetch_pc_q;

endmodule
`default_nettype wire
